arb_mux: RTL and testbench

- Parametrised successor to the 2:1 datapath select. It is an N-channel, valid/ready-handshaked, arbitrated multiplexer with a registered output stage.
- Several requesters share one consumer, for example instruction and data ports contending for a single memory/bus port in the pipelined CPU.
- Selection is by internal arbitration, fixed-priority or round-robin, instead of an external condition bit. The selected channel index is returned with the data.

---
 rtl/arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 41 ++++
 rtl/arb_mux.sv | 125 ++++++++++++
 tb/tb_arb_mux.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared constants for the arbitrated multiplexer (arb_mux) and its
// arbiter. Defines the arbitration mode encodings, the default data width and
// the saturation limit of the optional per-channel grant counters.
package arb_pkg;

   // Arbitration mode encodings for the MODE parameter
   localparam int ARB_FIXED = 0;   // lowest set index wins
   localparam int ARB_RR    = 1;   // round-robin starting at the pointer

   localparam int DEFAULT_WIDTH = 32;

   // Grant counters stick at this value instead of wrapping
   localparam logic [15:0] STAT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational arbiter. Picks one requester from req_i, either
// the lowest set index (rr_mode_i=0) or the first set index scanning upward
// from ptr_i with wrap-around (rr_mode_i=1). Returns a one-hot grant and the
// encoded index; both are zero when no request is set.
module rr_arbiter #(
   parameter  int NUM_CH = 4,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_i,
   input  logic [CH_W-1:0]   ptr_i,
   input  logic              rr_mode_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [CH_W-1:0]   idx_o
);

   int              slot;
   logic [CH_W-1:0] cand;

   // Scan candidates from lowest to highest priority so the last hit wins
   always_comb begin
      // NOTE: every output gets a default before the loop; a path that left
      // gnt_o/idx_o unassigned would infer a latch.
      gnt_o = '0;
      idx_o = '0;
      slot  = 0;
      cand  = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         // NOTE: blocking assignments here are intentional; slot/cand are
         // scratch values consumed later in the same evaluation.
         slot = rr_mode_i ? int'(ptr_i) + k : k;
         if (slot >= NUM_CH) slot = slot - NUM_CH;
         cand = CH_W'(slot);
         if (req_i[cand]) begin
            gnt_o       = '0;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// arb_mux: NUM_CH-channel valid/ready arbitrated multiplexer with a registered
// output stage. Arbitration is fixed-priority (MODE=ARB_FIXED) or round-robin
// (MODE=ARB_RR); the winning channel index travels with the data.
// Optional feature: define ARB_MUX_STATS_EN to add GrantCount, one 16-bit
// saturating transfer counter per channel.
module arb_mux
   import arb_pkg::*;
#(
   parameter  int WIDTH  = DEFAULT_WIDTH,
   parameter  int NUM_CH = 4,
   parameter  int MODE   = ARB_RR,
   localparam int CH_W   = $clog2(NUM_CH)
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic [NUM_CH-1:0]       InValid,
   input  logic [NUM_CH*WIDTH-1:0] InData,
   output logic [NUM_CH-1:0]       InReady,
   output logic                    OutValid,
   output logic [WIDTH-1:0]        OutData,
   output logic [CH_W-1:0]         OutChannel,
`ifdef ARB_MUX_STATS_EN
   output logic [NUM_CH*16-1:0]    GrantCount,
`endif
   input  logic                    OutReady
);

   logic              load;
   logic              xfer;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;
   logic [WIDTH-1:0]  sel_data;

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [CH_W-1:0]   out_ch_q,    out_ch_d;
   logic [CH_W-1:0]   ptr_q,       ptr_d;

   rr_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .req_i     (InValid),
      .ptr_i     (ptr_q),
      .rr_mode_i (MODE == ARB_RR),
      .gnt_o     (gnt),
      .idx_o     (gnt_idx)
   );

   // Output register can take a word when empty or being drained this cycle
   assign load    = !out_valid_q || OutReady;
   // Reset gates the handshake so no accept can leak out while Reset is low
   assign InReady = (Reset && load) ? gnt : '0;
   assign xfer    = |InReady;

   // Select the granted channel's data word
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) sel_data = InData[i*WIDTH +: WIDTH];
      end
   end

   // Next state of the output register and the round-robin pointer
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_data;
         out_ch_d    = gnt_idx;
         if (MODE == ARB_RR) begin
            ptr_d = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end else if (OutReady) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; Reset discards any held word and restarts at channel 0
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         ptr_q       <= '0;
      end else begin
         // NOTE: non-blocking for all state so every register samples the
         // pre-edge values regardless of statement order.
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         ptr_q       <= ptr_d;
      end
   end

   assign OutValid   = out_valid_q;
   assign OutData    = out_data_q;
   assign OutChannel = out_ch_q;

`ifdef ARB_MUX_STATS_EN
   logic [15:0] cnt_q [NUM_CH];

   // Per-channel saturating transfer counters
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         // NOTE: this array is a handful of flops, not a RAM, so clearing it
         // in the reset branch is cheap and gives software a known zero.
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (InValid[i] && InReady[i] && (cnt_q[i] != STAT_MAX)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
      assign GrantCount[i*16 +: 16] = cnt_q[i];
   end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed bench for arb_mux. Two instances share one stimulus:
// dut_fp (fixed priority) and dut_rr (round-robin). A behavioural model
// tracks both and is compared every cycle; directed steps add literal checks.
module tb_arb_mux;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic           out_ready;

   logic [N-1:0] fp_in_ready, rr_in_ready;
   logic         fp_out_valid, rr_out_valid;
   logic [W-1:0] fp_out_data, rr_out_data;
   logic [1:0]   fp_out_ch, rr_out_ch;
`ifdef ARB_MUX_STATS_EN
   logic [N*16-1:0] fp_gc, rr_gc;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(0)) dut_fp (
      .CLK        (clk),
      .Reset      (rst_n),
      .InValid    (in_valid),
      .InData     (in_data),
      .InReady    (fp_in_ready),
      .OutValid   (fp_out_valid),
      .OutData    (fp_out_data),
      .OutChannel (fp_out_ch),
`ifdef ARB_MUX_STATS_EN
      .GrantCount (fp_gc),
`endif
      .OutReady   (out_ready)
   );

   arb_mux #(.WIDTH(W), .NUM_CH(N), .MODE(1)) dut_rr (
      .CLK        (clk),
      .Reset      (rst_n),
      .InValid    (in_valid),
      .InData     (in_data),
      .InReady    (rr_in_ready),
      .OutValid   (rr_out_valid),
      .OutData    (rr_out_data),
      .OutChannel (rr_out_ch),
`ifdef ARB_MUX_STATS_EN
      .GrantCount (rr_gc),
`endif
      .OutReady   (out_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: index 0 = fixed, 1 = round-robin
   int          m_valid [2] = '{0, 0};
   logic [31:0] m_data  [2] = '{32'h0, 32'h0};
   int          m_ch    [2] = '{0, 0};
   int          m_ptr   [2] = '{0, 0};

   // Winner: walk channels in priority order, first requester wins; -1 = none
   function automatic int pick(input int m, input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         int c;
         c = (m == 1) ? (ptr + k) % N : k;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ready(input int m);
      int g;
      if (rst_n !== 1'b1) return '0;
      if (m_valid[m] != 0 && out_ready !== 1'b1) return '0;
      g = pick(m, in_valid, m_ptr[m]);
      if (g < 0) return '0;
      return N'(1 << g);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      logic [N-1:0] r;
      int g;
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            m_valid[m] = 0; m_data[m] = '0; m_ch[m] = 0; m_ptr[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            r = exp_ready(m);
            if (r != '0) begin
               g = pick(m, in_valid, m_ptr[m]);
               m_data[m]  = in_data[g*W +: W];
               m_ch[m]    = g;
               m_valid[m] = 1;
               if (m == 1) m_ptr[m] = (g + 1) % N;
            end else if (out_ready) begin
               m_valid[m] = 0;
            end
         end
      end
   end

   // Per-cycle comparison, sampled mid-way through the low clock phase
   always @(negedge clk) begin
      #2;
      check("fp_in_ready",  32'(fp_in_ready),  32'(exp_ready(0)));
      check("fp_out_valid", 32'(fp_out_valid), 32'(m_valid[0]));
      check("fp_out_data",  fp_out_data,       m_data[0]);
      check("fp_out_ch",    32'(fp_out_ch),    32'(m_ch[0]));
      check("rr_in_ready",  32'(rr_in_ready),  32'(exp_ready(1)));
      check("rr_out_valid", 32'(rr_out_valid), 32'(m_valid[1]));
      check("rr_out_data",  rr_out_data,       m_data[1]);
      check("rr_out_ch",    32'(rr_out_ch),    32'(m_ch[1]));
   end

   // ---------------- directed stimulus with literal expectations
   initial begin
      rst_n     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset held with random inputs
      repeat (3) begin
         @(negedge clk);
         in_valid  = N'($urandom);
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         out_ready = 1'($urandom);
      end
      #2;
      check("rst_out_valid", 32'(rr_out_valid), 32'd0);
      check("rst_out_data",  rr_out_data,       32'h0);
      check("rst_out_ch",    32'(rr_out_ch),    32'd0);
      check("rst_in_ready",  32'(rr_in_ready),  32'd0);
      check("rst_fp_in_ready", 32'(fp_in_ready), 32'd0);

      // Release with only channel 2 requesting
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 4'b0100;
      in_data[2*W +: W] = 32'hA5A5_0002;
      out_ready = 1'b1;
      #2;
      check("rel_rr_in_ready", 32'(rr_in_ready), 32'b0100);
      check("rel_fp_in_ready", 32'(fp_in_ready), 32'b0100);
      @(negedge clk);
      in_valid = '0;
      #2;
      check("rel_out_valid", 32'(rr_out_valid), 32'd1);
      check("rel_out_data",  rr_out_data,       32'hA5A5_0002);
      check("rel_out_ch",    32'(rr_out_ch),    32'd2);

      // Round-robin sweep from a fresh pointer
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 4'b1111;
      in_data   = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); #2;
         check("rr_seq_ch",    32'(rr_out_ch),    32'(k % 4));
         check("rr_seq_data",  rr_out_data,       32'h1000_0000 + 32'(k % 4));
         check("rr_seq_valid", 32'(rr_out_valid), 32'd1);
         check("rr_seq_ready", 32'(rr_in_ready),  32'(1 << ((k + 1) % 4)));
      end

      // Fixed priority: channel 1 starves channel 3
      @(negedge clk);
      in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #2;
         check("fp_hold_ch",    32'(fp_out_ch),   32'd1);
         check("fp_hold_ready", 32'(fp_in_ready), 32'b0010);
      end
      @(negedge clk);
      in_valid = 4'b1000;
      #2;
      check("fp_drop_ready", 32'(fp_in_ready), 32'b1000);
      @(negedge clk); #2;
      check("fp_drop_ch",   32'(fp_out_ch),   32'd3);
      check("fp_drop_data", fp_out_data,      32'h1000_0003);

      // Backpressure
      @(negedge clk);
      in_valid  = 4'b0001;
      in_data[0*W +: W] = 32'hDEAD_BEEF;
      in_data[1*W +: W] = 32'hCAFE_0001;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 4'b0010;
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #2;
         check("bp_data",     rr_out_data,       32'hDEAD_BEEF);
         check("bp_fp_data",  fp_out_data,       32'hDEAD_BEEF);
         check("bp_valid",    32'(rr_out_valid), 32'd1);
         check("bp_in_ready", 32'(rr_in_ready),  32'd0);
         check("bp_fp_ready", 32'(fp_in_ready),  32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #2;
      check("bp_release_ready", 32'(rr_in_ready), 32'b0010);
      @(negedge clk);
      in_valid = '0;
      #2;
      check("bp_release_ch",   32'(rr_out_ch), 32'd1);
      check("bp_release_data", rr_out_data,    32'hCAFE_0001);

      // Asynchronous reset mid-stream
      @(negedge clk);
      in_valid  = 4'b0001;
      in_data[0*W +: W] = 32'h1234_5678;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = '0;
      #2;
      check("mid_held_valid", 32'(rr_out_valid), 32'd1);
      check("mid_held_data",  rr_out_data,       32'h1234_5678);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rr_out_valid), 32'd0);
      check("mid_rst_data",  rr_out_data,       32'h0);
      check("mid_rst_fp",    32'(fp_out_valid), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 4'b1000;
      out_ready = 1'b1;
      #2;
      check("mid_first_ready", 32'(rr_in_ready), 32'b1000);
      @(negedge clk);
      in_valid = 4'b1111;
      #2;
      check("mid_first_ch",   32'(rr_out_ch),   32'd3);
      check("mid_wrap_ready", 32'(rr_in_ready), 32'b0001);
      @(negedge clk);
      in_valid = '0;
      #2;
      check("mid_wrap_ch", 32'(rr_out_ch), 32'd0);

`ifdef ARB_MUX_STATS_EN
      // Saturation of the channel 0 counter
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); #2;
      check("gc_reset", rr_gc[31:0], 32'h0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 4'b0001;
      out_ready = 1'b1;
      repeat (70000) @(negedge clk);
      #2;
      check("gc_rr_ch0_sat", 32'(rr_gc[15:0]),  32'h0000_FFFF);
      check("gc_fp_ch0_sat", 32'(fp_gc[15:0]),  32'h0000_FFFF);
      check("gc_rr_others",  rr_gc[63:32],      32'h0);
      check("gc_rr_ch1",     32'(rr_gc[31:16]), 32'h0);
      check("gc_fp_others",  fp_gc[63:16] == '0 ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk);
      in_valid = '0;
`endif

      repeat (3) @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
